// File: rtl/video_write_scheduler_pkg.sv
// video_write_scheduler_pkg: shared state encoding, widths and clamp helper
package video_write_scheduler_pkg;
  localparam int ADDR_W = 16;
  localparam int COORD_W = 8;
  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef enum logic [1:0] {VWS_IDLE, VWS_PREP, VWS_RUN, VWS_FINISH} vws_state_e;
  function automatic coord_t clamp(input coord_t v, input int lim);
    return (int'(v) > lim) ? coord_t'(lim) : v;
  endfunction
endpackage

// File: rtl/video_write_scheduler_if.sv
// video_write_scheduler_if: host request, fill command and video_memory write port
//  slave : scheduler view (consumes host/fill requests, drives video_* and status)
//  master: command decoder / memory-side view
interface video_write_scheduler_if import video_write_scheduler_pkg::*; #(parameter int ATTR_W = 24);
  logic              host_req, host_ack;
  addr_t             host_addr;
  logic [ATTR_W-1:0] host_value, host_mask;
  logic              fill_start, fill_abort, fill_busy, fill_done;
  coord_t            fill_x0, fill_x1, fill_y0, fill_y1;
  logic [ATTR_W-1:0] fill_value, fill_mask;
  logic              video_write;
  addr_t             video_address;
  logic [ATTR_W-1:0] video_value, video_mask;
  modport slave (
    input  host_req, host_addr, host_value, host_mask,
    input  fill_start, fill_abort, fill_x0, fill_x1, fill_y0, fill_y1, fill_value, fill_mask,
    output host_ack, fill_busy, fill_done, video_write, video_address, video_value, video_mask
  );
  modport master (
    output host_req, host_addr, host_value, host_mask,
    output fill_start, fill_abort, fill_x0, fill_x1, fill_y0, fill_y1, fill_value, fill_mask,
    input  host_ack, fill_busy, fill_done, video_write, video_address, video_value, video_mask
  );
endinterface

// File: rtl/video_write_scheduler_rect_scanner.sv
// video_write_scheduler_rect_scanner: x/y/row_base walker over a clamped rectangle
//  load_i  : latch bounds, x<=x0, y<=0, row_base<=0
//  prep_i  : step y/row_base up to y0 (ready_o when row_base = y0*COLS)
//  adv_i   : move to next cell in raster order
//  addr_o  : row_base + x;  last_o: current cell is (x1,y1)
module video_write_scheduler_rect_scanner import video_write_scheduler_pkg::*; #(
  parameter int COLS = 80
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   load_i,
  input  logic   prep_i,
  input  logic   adv_i,
  input  coord_t x0_i,
  input  coord_t x1_i,
  input  coord_t y0_i,
  input  coord_t y1_i,
  output addr_t  addr_o,
  output logic   last_o,
  output logic   ready_o
);
  coord_t x0_q, x1_q, y0_q, y1_q, x_q, x_d, y_q, y_d;
  addr_t rb_q, rb_d;
  logic wrap, step_y;
  // y doubles as the PREP counter, so row_base = y*COLS holds throughout
  always_comb begin
    wrap = x_q == x1_q;
    step_y = (prep_i && !ready_o) || (adv_i && wrap);
    x_d = load_i ? x0_i : adv_i ? (wrap ? x0_q : x_q + 1'b1) : x_q;
    y_d = load_i ? '0 : step_y ? y_q + 1'b1 : y_q;
    rb_d = load_i ? '0 : step_y ? rb_q + addr_t'(COLS) : rb_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {x0_q, x1_q, y0_q, y1_q, x_q, y_q} <= '0;
      rb_q <= '0;
    end else begin
      if (load_i) {x0_q, x1_q, y0_q, y1_q} <= {x0_i, x1_i, y0_i, y1_i};
      x_q <= x_d;
      y_q <= y_d;
      rb_q <= rb_d;
    end
  assign addr_o = rb_q + addr_t'(x_q);
  assign last_o = wrap && y_q == y1_q;
  assign ready_o = y_q == y0_q;
endmodule

// File: rtl/video_write_scheduler.sv
// video_write_scheduler: sole driver of video_memory writes; host single writes beat a rectangle-fill engine
//  clk, rst : clock, asynchronous active-high reset
//  bus      : slave modport -- host_req/addr/value/mask -> host_ack,
//             fill_start/abort/x0/x1/y0/y1/value/mask -> fill_busy/fill_done,
//             registered video_write/address/value/mask to video_memory
module video_write_scheduler import video_write_scheduler_pkg::*; #(
  parameter int COLS = 80,
  parameter int ROWS = 30,
  parameter int ATTR_W = 24
) (
  input logic clk,
  input logic rst,
  video_write_scheduler_if.slave bus
);
  localparam int CELLS = COLS * ROWS;
  vws_state_e state_q, state_d;
  logic host_ack_q, done_q, vw_q, vw_d;
  addr_t va_q, va_d, scan_addr;
  logic [ATTR_W-1:0] vv_q, vv_d, vm_q, vm_d, fv_q, fm_q;
  logic host_acc, host_ok, empty, fill_go, load, scan_last, scan_ready;
  coord_t x1c, y1c;
  always_comb begin
    host_acc = bus.host_req && !host_ack_q;
    host_ok = 17'(bus.host_addr) < 17'(CELLS);
    x1c = clamp(bus.fill_x1, COLS - 1);
    y1c = clamp(bus.fill_y1, ROWS - 1);
    empty = bus.fill_x0 > x1c || bus.fill_y0 > y1c;
    load = state_q == VWS_IDLE && bus.fill_start;
    // an accepted host request owns this cycle's write slot
    fill_go = state_q == VWS_RUN && !host_acc && !bus.fill_abort;
    state_d = state_q;
    case (state_q)
      VWS_IDLE:   state_d = bus.fill_start ? (empty ? VWS_FINISH : VWS_PREP) : VWS_IDLE;
      VWS_PREP:   state_d = bus.fill_abort ? VWS_FINISH : scan_ready ? VWS_RUN : VWS_PREP;
      VWS_RUN:    state_d = (bus.fill_abort || (fill_go && scan_last)) ? VWS_FINISH : VWS_RUN;
      VWS_FINISH: state_d = VWS_IDLE;
      default:    state_d = VWS_IDLE;
    endcase
    vw_d = host_acc ? host_ok : fill_go;
    va_d = host_acc ? bus.host_addr : fill_go ? scan_addr : va_q;
    vv_d = host_acc ? bus.host_value : fill_go ? fv_q : vv_q;
    vm_d = host_acc ? bus.host_mask : fill_go ? fm_q : vm_q;
  end
  video_write_scheduler_rect_scanner #(.COLS(COLS)) u_scan (
    .clk(clk), .rst(rst), .load_i(load), .prep_i(state_q == VWS_PREP), .adv_i(fill_go),
    .x0_i(bus.fill_x0), .x1_i(x1c), .y0_i(bus.fill_y0), .y1_i(y1c),
    .addr_o(scan_addr), .last_o(scan_last), .ready_o(scan_ready)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= VWS_IDLE;
      {host_ack_q, done_q, vw_q} <= '0;
      va_q <= '0;
      {vv_q, vm_q, fv_q, fm_q} <= '0;
    end else begin
      state_q <= state_d;
      host_ack_q <= host_acc;
      done_q <= state_q == VWS_FINISH;
      vw_q <= vw_d;
      va_q <= va_d;
      vv_q <= vv_d;
      vm_q <= vm_d;
      if (load) {fv_q, fm_q} <= {bus.fill_value, bus.fill_mask};
    end
  assign bus.host_ack = host_ack_q;
  assign bus.fill_busy = state_q == VWS_PREP || state_q == VWS_RUN;
  assign bus.fill_done = done_q;
  assign bus.video_write = vw_q;
  assign bus.video_address = va_q;
  assign bus.video_value = vv_q;
  assign bus.video_mask = vm_q;
endmodule

// File: tb/tb_video_write_scheduler.sv
// tb_video_write_scheduler: host write table plus fill/abort/reset sequences with a write scoreboard
module tb_video_write_scheduler;
  localparam int COLS = 8, ROWS = 4, AW = 24;
  typedef struct packed {logic [15:0] addr; logic [AW-1:0] val; logic [AW-1:0] mask;} wr_t;
  typedef struct {logic [15:0] addr; logic [AW-1:0] val, mask; logic exp_w; logic [AW-1:0] exp_mem;} hvec_t;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  video_write_scheduler_if #(.ATTR_W(AW)) bus();
  video_write_scheduler #(.COLS(COLS), .ROWS(ROWS), .ATTR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0, errors = 0, cyc = 0, fill_writes = 0, last_wr_cyc = 0, start_cyc = 0;
  wr_t hq[$], fq[$], mon_w;
  logic [AW-1:0] mem [COLS*ROWS];
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // video_memory model plus scoreboard: host writes matched by content, fill writes strictly in order
  always @(negedge clk)
    if (!rst && bus.video_write) begin
      mon_w = '{bus.video_address, bus.video_value, bus.video_mask};
      if (hq.size() > 0 && hq[0] == mon_w) begin
        void'(hq.pop_front());
        checks++;
      end else if (fq.size() > 0) begin
        chk("fill_write", mon_w, fq[0]);
        void'(fq.pop_front());
        fill_writes++;
        last_wr_cyc = cyc;
      end else chk("unexpected_write", {48'd0, mon_w.addr}, 64'hFFFF_FFFF);
      if (mon_w.addr < COLS*ROWS) mem[mon_w.addr] = (mem[mon_w.addr] & ~mon_w.mask) | (mon_w.val & mon_w.mask);
    end
  task automatic host_write(input logic [15:0] a, input logic [AW-1:0] v, input logic [AW-1:0] m, input logic ew);
    if (ew) hq.push_back('{a, v, m});
    @(negedge clk);
    bus.host_req = 1; bus.host_addr = a; bus.host_value = v; bus.host_mask = m;
    @(posedge clk); #1;
    chk("host_ack", bus.host_ack, 1);
    chk("host_video_write", bus.video_write, ew);
    bus.host_req = 0;
    @(negedge clk); #1;
  endtask
  task automatic fill_begin(input int x0, input int x1, input int y0, input int y1,
                            input logic [AW-1:0] v, input logic [AW-1:0] m, output int n);
    int x1c, y1c;
    x1c = x1 > COLS-1 ? COLS-1 : x1;
    y1c = y1 > ROWS-1 ? ROWS-1 : y1;
    n = 0;
    for (int y = y0; y <= y1c; y++)
      for (int x = x0; x <= x1c; x++) begin
        fq.push_back('{16'(y*COLS + x), v, m});
        n++;
      end
    fill_writes = 0;
    @(negedge clk);
    bus.fill_start = 1; bus.fill_x0 = 8'(x0); bus.fill_x1 = 8'(x1); bus.fill_y0 = 8'(y0); bus.fill_y1 = 8'(y1);
    bus.fill_value = v; bus.fill_mask = m;
    @(negedge clk);
    bus.fill_start = 0;
    #1;
    start_cyc = cyc;
    chk("busy_after_start", bus.fill_busy, n > 0);
  endtask
  task automatic fill_wait(input int abort_after, input int exp_n);
    int n = 0;
    bit got = 0, ab = 0;
    while (!got && n < 200) begin
      @(negedge clk); #1;
      n++;
      bus.fill_abort = abort_after > 0 && !ab && fill_writes == abort_after;
      if (bus.fill_abort) ab = 1;
      got = bus.fill_done;
    end
    bus.fill_abort = 0;
    chk("fill_done_seen", got, 1);
    chk("fill_write_count", fill_writes, exp_n);
    chk("fill_done_timing", cyc, exp_n == 0 ? start_cyc + 1 : last_wr_cyc + (abort_after > 0 ? 2 : 1));
    @(negedge clk); #1;
    chk("fill_done_pulse", bus.fill_done, 0);
    if (abort_after > 0) fq.delete();
    else chk("fill_queue_empty", fq.size(), 0);
  endtask
  initial begin
    hvec_t tv[6];
    logic [AW-1:0] acc;
    int n, k;
    bit bad;
    for (int i = 0; i < COLS*ROWS; i++) mem[i] = '0;
    bus.host_req = 0; bus.host_addr = 0; bus.host_value = 0; bus.host_mask = 0;
    bus.fill_start = 0; bus.fill_abort = 0; bus.fill_x0 = 0; bus.fill_x1 = 0; bus.fill_y0 = 0; bus.fill_y1 = 0;
    bus.fill_value = 0; bus.fill_mask = 0;
    tv[0] = '{16'd5, 24'h00A141, 24'hFFFFFF, 1'b1, 24'h00A141};
    tv[1] = '{16'd31, 24'h123456, 24'h0000FF, 1'b1, 24'h000056};
    tv[2] = '{16'd0, 24'hABCDEF, 24'hF0F0F0, 1'b1, 24'hA0C0E0};
    tv[3] = '{16'd32, 24'h111111, 24'hFFFFFF, 1'b0, 24'h0};
    tv[4] = '{16'd40, 24'h222222, 24'hFFFFFF, 1'b0, 24'h0};
    tv[5] = '{16'hFFFF, 24'h333333, 24'hFFFFFF, 1'b0, 24'h0};
    repeat (2) @(negedge clk);
    chk("reset_outputs", {bus.video_write, bus.host_ack, bus.fill_busy, bus.fill_done, bus.video_address}, 0);
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      host_write(tv[i].addr, tv[i].val, tv[i].mask, tv[i].exp_w);
      if (tv[i].exp_w) chk("mem_cell", mem[tv[i].addr], tv[i].exp_mem);
      if (i == 0) begin
        acc = '0;
        for (int j = 0; j < COLS*ROWS; j++) if (j != int'(tv[0].addr)) acc |= mem[j];
        chk("mem_others_unchanged", acc, 0);
      end
    end
    fill_begin(1, 2, 1, 2, 24'h111111, 24'hFFFFFF, n);
    fill_wait(0, n);
    fill_begin(0, 20, 3, 9, 24'h222222, 24'hFFFFFF, n);
    fill_wait(0, n);
    fill_begin(0, 7, 0, 3, 24'h000020, 24'h0000FF, n);
    repeat (4) @(negedge clk);
    host_write(16'd12, 24'hFACE00, 24'hFFFFFF, 1'b1);
    fill_wait(0, 32);
    fill_begin(5, 2, 0, 1, 24'h444444, 24'hFFFFFF, n);
    fill_wait(0, 0);
    fill_begin(0, 7, 0, 3, 24'h555555, 24'hFFFFFF, n);
    fill_wait(3, 3);
    fill_begin(0, 7, 0, 3, 24'h666666, 24'hFFFFFF, n);
    k = 0;
    while (fill_writes < 2 && k < 100) begin
      @(negedge clk); #1;
      k++;
    end
    chk("reset_fill_progress", fill_writes >= 2, 1);
    #2 rst = 1;
    #1 chk("async_reset_outputs", {bus.video_write, bus.host_ack, bus.fill_busy, bus.fill_done, bus.video_address,
                                   bus.video_value}, 0);
    @(negedge clk);
    rst = 0;
    fq.delete();
    bad = 0;
    repeat (6) begin
      @(negedge clk); #1;
      if (bus.fill_done || bus.fill_busy || bus.video_write) bad = 1;
    end
    chk("no_done_after_reset", bad, 0);
    host_write(16'd40, 24'h777777, 24'hFFFFFF, 1'b0);
    chk("host_queue_empty", hq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
